// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolver: condition codes, state encoding
// and common widths.
package branch_pkg;

  localparam int unsigned CC_W  = 2;
  localparam int unsigned CNT_W = 16;

  localparam logic [CC_W-1:0] CC_EQ = 2'b00;
  localparam logic [CC_W-1:0] CC_GE = 2'b01;
  localparam logic [CC_W-1:0] CC_LT = 2'b10;
  localparam logic [CC_W-1:0] CC_NE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EVAL = 2'b01,
    ST_RESP = 2'b10
  } state_e;

endpackage : branch_pkg

// File: rtl/branch_resolver_cond_eval.sv
// Combinational branch-condition evaluation on unsigned operands.
module cond_eval
  import branch_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [CC_W-1:0]   cond_i,
  output logic              flag_o
);

  logic a_eq_b;
  logic a_lt_b;

  assign a_eq_b = (a_i == b_i);
  assign a_lt_b = (a_i < b_i);

  always_comb begin
    flag_o = 1'b0;
    unique case (cond_i)
      CC_EQ:   flag_o = a_eq_b;
      CC_GE:   flag_o = !a_lt_b;
      CC_LT:   flag_o = a_lt_b;
      CC_NE:   flag_o = !a_eq_b;
      default: flag_o = 1'b0;
    endcase
  end

endmodule : cond_eval

// File: rtl/branch_resolver.sv
// Branch sequencer: owns the PC and taken-branch counter, evaluates latched
// branch requests and reports the outcome over a valid/ready response.
module branch_resolver
  import branch_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned PC_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_inc,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_uncond,
  input  logic [CC_W-1:0]   req_cond,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic [PC_W-1:0]   req_target,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_taken,
  output logic [PC_W-1:0]   pc,
  output logic              redirect,
  output logic              stall,
  output logic [CNT_W-1:0]  taken_cnt
);

  state_e              state_q;
  logic [DATA_W-1:0]   a_q;
  logic [DATA_W-1:0]   b_q;
  logic [CC_W-1:0]     cond_q;
  logic                uncond_q;
  logic [PC_W-1:0]     target_q;
  logic [PC_W-1:0]     pc_q;
  logic [CNT_W-1:0]    taken_cnt_q;
  logic                resp_valid_q;
  logic                resp_taken_q;
  logic                redirect_q;
  logic                stall_q;

  logic                cond_flag;
  logic                taken_d;
  logic [PC_W-1:0]     pc_step_d;

  // Condition is evaluated only on latched operands, never on live inputs.
  cond_eval #(
    .DATA_W (DATA_W)
  ) u_cond_eval (
    .a_i    (a_q),
    .b_i    (b_q),
    .cond_i (cond_q),
    .flag_o (cond_flag)
  );

  assign taken_d   = uncond_q | cond_flag;
  assign pc_step_d = pc_q + PC_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      a_q          <= '0;
      b_q          <= '0;
      cond_q       <= CC_EQ;
      uncond_q     <= 1'b0;
      target_q     <= '0;
      pc_q         <= '0;
      taken_cnt_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_taken_q <= 1'b0;
      redirect_q   <= 1'b0;
      stall_q      <= 1'b0;
    end else begin
      // redirect is a single-cycle pulse, independent of response back-pressure
      redirect_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            a_q      <= req_a;
            b_q      <= req_b;
            cond_q   <= req_cond;
            uncond_q <= req_uncond;
            target_q <= req_target;
            state_q  <= ST_EVAL;
            stall_q  <= 1'b1;
          end else if (pc_inc) begin
            pc_q <= pc_step_d;
          end
        end
        ST_EVAL: begin
          resp_taken_q <= taken_d;
          resp_valid_q <= 1'b1;
          if (taken_d) begin
            pc_q        <= target_q;
            redirect_q  <= 1'b1;
            taken_cnt_q <= taken_cnt_q + CNT_W'(1);
          end else begin
            pc_q <= pc_step_d;
          end
          state_q <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= ST_IDLE;
            stall_q      <= 1'b0;
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          resp_valid_q <= 1'b0;
          stall_q      <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = (state_q == ST_IDLE) & !rst;
  assign resp_valid = resp_valid_q;
  assign resp_taken = resp_taken_q;
  assign pc         = pc_q;
  assign redirect   = redirect_q;
  assign stall      = stall_q;
  assign taken_cnt  = taken_cnt_q;

endmodule : branch_resolver
